// File: rtl/pipe_pkg.sv
// Shared pipeline types: writeback bundle, skid buffer state encoding, x0 index.
package pipe_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    // The EX->MEM writeback bundle at the default widths.
    typedef struct packed {
        logic [RADDR_W_DEF-1:0] rd_addr;
        logic [XLEN_DEF-1:0]    rd;
        logic                   writeback_en;
        logic                   writeback_from_mem;
    } wb_bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Architectural zero register; writes to it are squashed.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/ex_m_skid_reg_skid_buffer.sv
// Generic payload-width valid/ready buffer with synchronous flush.
// SKID_EN = 1: two entries, in_ready decoded from the state register only,
// so downstream back-pressure never reaches the upstream combinationally.
// SKID_EN = 0: one entry, in_ready = out_ready || !out_valid.
module skid_buffer
    import pipe_pkg::*;
#(
    parameter int W       = 8,
    parameter bit SKID_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state_q, state_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept;
    logic         consume;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_data_q;

    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = (state_q != FULL);
        end else begin : g_single
            assign in_ready = out_ready || !out_valid;
        end
    endgenerate

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Next-state and entry updates; flush empties the buffer and drops any incoming bundle.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        out_data_d = in_data;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        out_data_d = in_data;
                    end else if (accept && SKID_EN) begin
                        state_d     = FULL;
                        skid_data_d = in_data;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d     = ONE;
                        out_data_d  = skid_data_q;
                        skid_data_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and entry registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: the data entries are reset too, because the outputs must read zero after reset.
        if (!rst) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: rtl/ex_m_skid_reg.sv
// EX->MEM pipeline register: skid-buffered writeback bundle with flush,
// x0 write squashing and a saturating stall counter.
module ex_m_skid_reg
    import pipe_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter bit SKID_EN     = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RADDR_W-1:0]     rd_addr_in,
    input  logic [XLEN-1:0]        rd_in,
    input  logic                   writeback_en_in,
    input  logic                   writeback_from_mem_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RADDR_W-1:0]     rd_addr_out,
    output logic [XLEN-1:0]        rd_out,
    output logic                   writeback_en_out,
    output logic                   writeback_from_mem_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PAYLOAD_W = RADDR_W + XLEN + 2;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    logic                   wb_en_squashed;
    logic [PAYLOAD_W-1:0]   payload_in;
    logic [PAYLOAD_W-1:0]   payload_out;
    logic                   wb_en_stored;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // A write to x0 is architecturally a no-op, so drop its enable on entry.
    assign wb_en_squashed = writeback_en_in && (rd_addr_in != RADDR_W'(REG_ZERO));
    assign payload_in     = {rd_addr_in, rd_in, wb_en_squashed, writeback_from_mem_in};

    skid_buffer #(
        .W       (PAYLOAD_W),
        .SKID_EN (SKID_EN)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (payload_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (payload_out)
    );

    assign {rd_addr_out, rd_out, wb_en_stored, writeback_from_mem_out} = payload_out;
    // A bubble never writes, even when stale data remains after a flush.
    assign writeback_en_out = out_valid && wb_en_stored;
    assign stall_cnt        = stall_cnt_q;

    // Count cycles where EX is blocked, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && !flush && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_ex_m_skid_reg.sv
// Directed bench for ex_m_skid_reg with a FIFO-level reference model.
module tb_ex_m_skid_reg;
    import pipe_pkg::*;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       rd_addr_in = '0;
    logic [31:0]      rd_in = '0;
    logic             writeback_en_in = 1'b0;
    logic             writeback_from_mem_in = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [4:0]       rd_addr_out;
    logic [31:0]      rd_out;
    logic             writeback_en_out;
    logic             writeback_from_mem_out;
    logic [CNT_W-1:0] stall_cnt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_m_skid_reg #(
        .XLEN        (32),
        .RADDR_W     (5),
        .SKID_EN     (1'b1),
        .STALL_CNT_W (CNT_W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .flush                  (flush),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .rd_addr_in             (rd_addr_in),
        .rd_in                  (rd_in),
        .writeback_en_in        (writeback_en_in),
        .writeback_from_mem_in  (writeback_from_mem_in),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .rd_addr_out            (rd_addr_out),
        .rd_out                 (rd_out),
        .writeback_en_out       (writeback_en_out),
        .writeback_from_mem_out (writeback_from_mem_out),
        .stall_cnt              (stall_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the block is a FIFO of at most two bundles whose head is on the outputs.
    wb_bundle_t mq[$];
    int         m_cnt   = 0;
    bit         m_zero  = 1'b1;
    bit         started = 1'b0;

    always @(posedge clk) begin
        bit rdy;
        wb_bundle_t b;
        if (!rst) begin
            mq.delete();
            m_cnt  = 0;
            m_zero = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            rdy = (mq.size() < 2);
            if (in_valid && !rdy && m_cnt < CNT_MAX) m_cnt++;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
                b.rd_addr            = rd_addr_in;
                b.rd                 = rd_in;
                b.writeback_en       = writeback_en_in && (rd_addr_in != 5'd0);
                b.writeback_from_mem = writeback_from_mem_in;
                mq.push_back(b);
                m_zero = 1'b0;
            end
        end
        started = 1'b1;
    end

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
            check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
            if (mq.size() > 0) begin
                check("rd_addr_out", 64'(rd_addr_out), 64'(mq[0].rd_addr));
                check("rd_out", 64'(rd_out), 64'(mq[0].rd));
                check("wb_en_out", 64'(writeback_en_out), 64'(mq[0].writeback_en));
                check("wb_mem_out", 64'(writeback_from_mem_out), 64'(mq[0].writeback_from_mem));
            end else begin
                check("bubble_wb_en", 64'(writeback_en_out), 64'd0);
                if (m_zero) begin
                    check("reset_rd_addr", 64'(rd_addr_out), 64'd0);
                    check("reset_rd", 64'(rd_out), 64'd0);
                    check("reset_wb_mem", 64'(writeback_from_mem_out), 64'd0);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic en, input logic mem);
        in_valid              = v;
        rd_addr_in            = a;
        rd_in                 = d;
        writeback_en_in       = en;
        writeback_from_mem_in = mem;
    endtask

    initial begin
        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        check("t_rst_valid", 64'(out_valid), 64'd0);
        check("t_rst_ready", 64'(in_ready), 64'd1);
        check("t_rst_rd", 64'(rd_out), 64'd0);
        check("t_rst_cnt", 64'(stall_cnt), 64'd0);

        // Pass-through with one cycle latency.
        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk);
        check("t_pass_valid", 64'(out_valid), 64'd1);
        check("t_pass_addr", 64'(rd_addr_out), 64'd5);
        check("t_pass_rd", 64'(rd_out), 64'hDEADBEEF);
        check("t_pass_wb", 64'(writeback_en_out), 64'd1);

        // Stream 8 bundles back to back.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(i + 1), 32'(i * 32'h11), 1'b1, 1'(i % 2));
            @(negedge clk);
            check("t_stream_valid", 64'(out_valid), 64'd1);
        end
        check("t_stream_last", 64'(rd_out), 64'h77);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("t_stream_drain", 64'(out_valid), 64'd0);

        // Back-pressure: A held, B in skid, C waits.
        out_ready = 1'b0;
        drive(1'b1, 5'd1, 32'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd2, 32'd2, 1'b1, 1'b0);
        @(negedge clk);
        check("t_bp_full_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 5'd3, 32'd3, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("t_bp_hold_a", 64'(rd_out), 64'd1);
        check("t_bp_cnt2", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("t_bp_out_b", 64'(rd_out), 64'd2);
        check("t_bp_cnt3", 64'(stall_cnt), 64'd3);
        @(negedge clk);
        check("t_bp_out_c", 64'(rd_out), 64'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("t_bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL, with an incoming bundle.
        out_ready = 1'b0;
        drive(1'b1, 5'd4, 32'h44, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t_fl_valid", 64'(out_valid), 64'd0);
        check("t_fl_wb", 64'(writeback_en_out), 64'd0);
        check("t_fl_ready", 64'(in_ready), 64'd1);
        check("t_fl_cnt", 64'(stall_cnt), 64'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // x0 squash keeps the data, drops the enable.
        drive(1'b1, 5'd0, 32'h1234, 1'b1, 1'b1);
        @(negedge clk);
        check("t_x0_valid", 64'(out_valid), 64'd1);
        check("t_x0_rd", 64'(rd_out), 64'h1234);
        check("t_x0_wb", 64'(writeback_en_out), 64'd0);
        check("t_x0_mem", 64'(writeback_from_mem_out), 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);

        // Stall counter saturation: 2 accepts then 10 stalled cycles from 3.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 5'(9 + i), 32'(100 + i), 1'b1, 1'b0);
            @(negedge clk);
            if (i == 3) check("t_sat_cnt5", 64'(stall_cnt), 64'd5);
        end
        check("t_sat_cnt7", 64'(stall_cnt), 64'd7);
        check("t_sat_hold", 64'(rd_out), 64'd100);

        // Reset while FULL.
        rst = 1'b0;
        @(negedge clk);
        check("t_mrst_valid", 64'(out_valid), 64'd0);
        check("t_mrst_addr", 64'(rd_addr_out), 64'd0);
        check("t_mrst_rd", 64'(rd_out), 64'd0);
        check("t_mrst_wb", 64'(writeback_en_out), 64'd0);
        check("t_mrst_ready", 64'(in_ready), 64'd1);
        check("t_mrst_cnt", 64'(stall_cnt), 64'd0);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("t_mrst_nothing", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_m_skid_reg.md
Name: ex_m_skid_reg

Overview:
- Parametrised successor to the EX->MEM pipeline register. Carries the writeback bundle (rd address, rd value, writeback enable, writeback-from-memory) from EX to MEM.
- Uses a valid/ready handshake with a 2-entry skid buffer, so MEM back-pressure never combinationally reaches EX.
- Adds a synchronous flush for branch mispredict and trap, x0 write squashing, and a saturating stall counter for performance monitoring.

Parameters:
- XLEN, 32, width of rd_in / rd_out.
- RADDR_W, 5, width of register addresses.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with in_ready = out_ready || !out_valid (combinational).
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- flush  input  1  discard all held and incoming entries this cycle.
- in_valid  input  1  EX presents a bundle.
- in_ready  output  1  block accepts when in_valid && in_ready.
- rd_addr_in  input  RADDR_W  destination register.
- rd_in  input  XLEN  result value.
- writeback_en_in  input  1  write the register file.
- writeback_from_mem_in  input  1  writeback data comes from memory.
- out_valid  output  1  bundle presented to MEM.
- out_ready  input  1  MEM consumes when out_valid && out_ready.
- rd_addr_out  output  RADDR_W  registered.
- rd_out  output  XLEN  registered.
- writeback_en_out  output  1  registered.
- writeback_from_mem_out  output  1  registered.
- stall_cnt  output  STALL_CNT_W  cycles with in_valid && !in_ready.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - out_valid = 0, rd_addr_out = 0, rd_out = 0, writeback_en_out = 0, writeback_from_mem_out = 0.
  - Skid buffer empty, stall_cnt = 0, in_ready = 1 from the first cycle after reset.
  - All inputs, including flush, are ignored while rst == 0.
- Latency: an accepted bundle appears on the outputs exactly 1 cycle after acceptance when the block was EMPTY or draining. Throughput is 1 bundle per cycle with out_ready held high.
- x0 squash: if rd_addr_in == 0 at acceptance, the stored writeback_en is forced to 0. The other fields are stored unchanged.
- Output fields hold their values while out_valid && !out_ready (stable-until-consumed).
- States when SKID_EN = 1 (in_ready = (state != FULL), registered):
  - EMPTY: accept -> ONE.
  - ONE:
    - accept with no consume -> FULL; the new bundle goes to the skid entry.
    - accept with consume -> ONE; output takes the new bundle.
    - consume with no accept -> EMPTY.
  - FULL:
    - consume -> ONE; output takes the skid entry, skid cleared.
    - no accept is possible because in_ready = 0.
- SKID_EN = 0: only EMPTY and ONE exist; in_ready = out_ready || !out_valid.
- Flush (highest priority after reset):
  - Next state is EMPTY and out_valid = 0.
  - A same-cycle incoming bundle is discarded, even if in_ready was 1.
  - Output data fields are not required to clear, but writeback_en_out must read 0 while out_valid == 0.
- When out_valid == 0, writeback_en_out = 0 always (bubble is a non-writing entry).
- stall_cnt:
  - Increments by 1 each non-reset cycle with in_valid && !in_ready && !flush.
  - Saturates at 2^STALL_CNT_W - 1; it does not wrap.
  - Cleared only by reset.

Decomposition:
- Shared package pipe_pkg holds:
  - the wb_bundle_t packed struct {rd_addr, rd, writeback_en, writeback_from_mem}, sized from XLEN/RADDR_W defaults;
  - the skid_state_t enum {EMPTY, ONE, FULL};
  - the constant REG_ZERO = 0.
- One natural sub-module: skid_buffer. It is a generic, payload-width-parametrised 2-entry valid/ready buffer with flush. ex_m_skid_reg wraps it and adds x0 squash and stall_cnt.

Test Plan:
- Reset and pass-through: hold rst = 0 for 2 cycles, then in_valid = 1, rd_addr_in = 5, rd_in = 0xDEADBEEF, writeback_en_in = 1, out_ready = 1 -> next cycle out_valid = 1, rd_addr_out = 5, rd_out = 0xDEADBEEF, writeback_en_out = 1. Streaming 8 bundles gives 8 consecutive outputs.
- Back-pressure: out_ready = 0 while sending bundles A = 1, B = 2, C = 3 -> A is held on the outputs, B goes to skid, in_ready = 0, C waits on EX. Raise out_ready -> outputs A, B, C in order, no loss or duplication. stall_cnt counts the stalled cycles.
- Flush in FULL: fill both entries, then assert flush together with in_valid = 1 -> next cycle out_valid = 0, writeback_en_out = 0, in_ready = 1. No flushed bundle is ever emitted.
- x0 squash: rd_addr_in = 0, rd_in = 0x1234, writeback_en_in = 1 -> rd_out = 0x1234, writeback_en_out = 0.
- Stall counter saturation: STALL_CNT_W = 3, out_ready = 0, in_valid = 1 for 12 cycles -> stall_cnt reaches 7 and holds at 7. A later reset returns it to 0.
- Reset mid-operation: assert rst = 0 while in state FULL -> next cycle out_valid = 0, all output fields 0, in_ready = 1. Neither buffered bundle appears after reset deasserts.
